// File: rtl/scramble_sequencer_if.sv
// scramble_sequencer_if: control and move-output bundle of the scramble sequencer
interface scramble_sequencer_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       fire;
  logic       x_nRow;
  logic [3:0] row_column;
  logic [7:0] moves_left;
  modport master (input start, abort, output busy, done, fire, x_nRow, row_column, moves_left);
  modport slave (output start, abort, input busy, done, fire, x_nRow, row_column, moves_left);
endinterface

// File: rtl/scramble_sequencer.sv
// scramble_sequencer: paced burst of pseudo-random row/column moves; optional macro NO_UNDO_EN
module scramble_sequencer #(
  parameter int          NUM_MOVES  = 16,
  parameter int          GAP_CYCLES = 1000000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic                  clk,
  input logic                  rst_n,
  scramble_sequencer_if.master bus
);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;
  state_t        state_q, state_d;
  logic [15:0]   lfsr_q;
  logic          start_q;
  logic [7:0]    ml_q, ml_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          x_q, x_d;
  logic [3:0]    rc_q, rc_d;
  logic          fire, accept, rep;
  logic          x_draw;
  logic [3:0]    rc_draw;
  assign x_draw  = lfsr_q[2];
  assign rc_draw = 4'b0001 << lfsr_q[1:0];
  assign accept  = state_q == IDLE && bus.start && !start_q && !bus.abort;
`ifdef NO_UNDO_EN
  logic [4:0] prev_q;
  // prev clears to zero, which can never equal a one-hot draw
  assign rep = {x_q, rc_q} == prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= '0;
    else if (accept) prev_q <= '0;
    else if (fire) prev_q <= {x_q, rc_q};
`else
  assign rep = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ml_d    = ml_q;
    gap_d   = gap_q;
    x_d     = x_q;
    rc_d    = rc_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        ml_d    = 8'(NUM_MOVES);
        state_d = NUM_MOVES == 0 ? DONE : ISSUE;
        x_d     = x_draw;
        rc_d    = rc_draw;
      end
      ISSUE: begin
        if (rep) begin
          x_d  = x_draw;
          rc_d = rc_draw;
        end else begin
          fire    = 1'b1;
          ml_d    = ml_q - 8'd1;
          gap_d   = GW'(GAP_CYCLES - 2);
          state_d = GAP;
        end
        if (bus.abort) begin
          state_d = IDLE;
          ml_d    = '0;
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == '0) begin
          state_d = ml_q != '0 ? ISSUE : DONE;
          x_d     = x_draw;
          rc_d    = rc_draw;
        end
        if (bus.abort) begin
          state_d = IDLE;
          ml_d    = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      start_q <= 1'b0;
      ml_q    <= '0;
      gap_q   <= '0;
      x_q     <= 1'b0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      start_q <= bus.start;
      ml_q    <= ml_d;
      gap_q   <= gap_d;
      x_q     <= x_d;
      rc_q    <= rc_d;
    end
  assign bus.busy       = state_q == ISSUE || state_q == GAP;
  assign bus.done       = state_q == DONE;
  assign bus.fire       = fire;
  assign bus.x_nRow     = x_q;
  assign bus.row_column = bus.busy ? rc_q : 4'b0000;
  assign bus.moves_left = ml_q;
endmodule
